// File: rtl/ex_stage.sv
// ex_stage: execute stage of a simple in-order pipeline.
//
// Takes one instruction from ID through a valid/ready handshake, computes an
// ALU result or a memory address, and holds it in the EX/WB output register
// until WB consumes it. Memory ops always produce operand_a_i + operand_b_i.
//
// Configuration macro: EX_MUL_EN
//   defined   : MUL (4'b1010) runs as a 4-step byte-serial multiply
//               (IDLE -> MUL_BUSY for four edges -> IDLE with the result).
//   undefined : no MUL_BUSY state, no accumulator; MUL finishes in one cycle
//               with wb_data_o = 0.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   valid_i / ready_o : ID -> EX handshake; ready_o is combinational
//   operand_a_i/_b_i  : ALU operands, or base/offset for loads and stores
//   alu_op_i          : operation select
//   store_data_i      : rs2 value for stores
//   load_type_i       : load code, nonzero = load active
//   store_type_i      : store code, nonzero = store active
//   rd_addr_i/reg_we_i: destination register and write enable
//   wb_ready_i        : WB consumes the current output this cycle
//   valid_o           : output register holds a valid instruction
//   wb_data_o         : ALU result or memory address
//   store_data_o, load_type_o, store_type_o, rd_addr_o, reg_we_o :
//                       registered copies of the matching inputs
module ex_stage #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WORD_WIDTH-1:0] operand_a_i,
  input  logic [WORD_WIDTH-1:0] operand_b_i,
  input  logic [3:0]            alu_op_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  reg_we_i,
  input  logic                  wb_ready_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] wb_data_o,
  output logic [WORD_WIDTH-1:0] store_data_o,
  output logic [2:0]            load_type_o,
  output logic [1:0]            store_type_o,
  output logic [4:0]            rd_addr_o,
  output logic                  reg_we_o
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpSll  = 4'b0010;
  localparam logic [3:0] OpSlt  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpAnd  = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;

  logic                  w_mem_op;
  logic [4:0]            w_shamt;
  logic [WORD_WIDTH-1:0] w_alu_result;
  logic [WORD_WIDTH-1:0] w_exec_result;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_mul_start;
  logic                  w_mul_done;
  logic [WORD_WIDTH-1:0] w_mul_result;

  logic                  r_valid;
  logic [WORD_WIDTH-1:0] r_wb_data;
  logic [WORD_WIDTH-1:0] r_store_data;
  logic [2:0]            r_load_type;
  logic [1:0]            r_store_type;
  logic [4:0]            r_rd_addr;
  logic                  r_reg_we;

  assign w_mem_op = (|load_type_i) || (|store_type_i);
  assign w_shamt  = operand_b_i[4:0];

  // MUL yields 0 here; the serial multiplier (when built) supplies its result.
  always_comb begin
    w_alu_result = '0;
    case (alu_op_i)
      OpAdd:   w_alu_result = operand_a_i + operand_b_i;
      OpSub:   w_alu_result = operand_a_i - operand_b_i;
      OpSll:   w_alu_result = operand_a_i << w_shamt;
      OpSlt:   w_alu_result = {{(WORD_WIDTH-1){1'b0}},
                               ($signed(operand_a_i) < $signed(operand_b_i))};
      OpSltu:  w_alu_result = {{(WORD_WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
      OpXor:   w_alu_result = operand_a_i ^ operand_b_i;
      OpSrl:   w_alu_result = operand_a_i >> w_shamt;
      OpSra:   w_alu_result = $signed(operand_a_i) >>> w_shamt;
      OpOr:    w_alu_result = operand_a_i | operand_b_i;
      OpAnd:   w_alu_result = operand_a_i & operand_b_i;
      default: w_alu_result = '0;
    endcase
  end

  // Memory ops override alu_op_i and compute the effective address.
  assign w_exec_result = w_mem_op ? (operand_a_i + operand_b_i) : w_alu_result;

  assign ready_o  = w_idle && (!r_valid || wb_ready_i);
  assign w_accept = valid_i && ready_o;

`ifdef EX_MUL_EN
  typedef enum logic [0:0] {StIdle, StMulBusy} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_cnt;
  logic [WORD_WIDTH-1:0] r_acc;
  logic [WORD_WIDTH-1:0] r_mul_a;
  logic [WORD_WIDTH-1:0] r_mul_b;
  logic [7:0]            w_b_byte;
  logic [WORD_WIDTH-1:0] w_partial;

  assign w_idle      = (r_state == StIdle);
  assign w_mul_start = w_accept && (alu_op_i == OpMul) && !w_mem_op;
  assign w_mul_done  = (r_state == StMulBusy) && (r_cnt == 2'd3);

  // Partial product for byte k of b, aligned to bit 8k; truncation is modulo 2^WORD_WIDTH.
  assign w_b_byte     = 8'(r_mul_b >> {r_cnt, 3'b000});
  assign w_partial    = (r_mul_a * {{(WORD_WIDTH-8){1'b0}}, w_b_byte}) << {r_cnt, 3'b000};
  assign w_mul_result = r_acc + w_partial;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_mul_start) w_state_next = StMulBusy;
      StMulBusy: if (w_mul_done)  w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_acc   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_mul_start) begin
        r_cnt   <= 2'd0;
        r_acc   <= '0;
        r_mul_a <= operand_a_i;
        r_mul_b <= operand_b_i;
      end else if (r_state == StMulBusy) begin
        r_cnt <= r_cnt + 2'd1;
        r_acc <= w_mul_result;
      end
    end
  end
`else
  assign w_idle       = 1'b1;
  assign w_mul_start  = 1'b0;
  assign w_mul_done   = 1'b0;
  assign w_mul_result = '0;
`endif

  // EX/WB output register: loads only on acceptance or multiply completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_wb_data    <= '0;
      r_store_data <= '0;
      r_load_type  <= 3'd0;
      r_store_type <= 2'd0;
      r_rd_addr    <= 5'd0;
      r_reg_we     <= 1'b0;
    end else if (w_accept) begin
      r_store_data <= store_data_i;
      r_load_type  <= load_type_i;
      r_store_type <= store_type_i;
      r_rd_addr    <= rd_addr_i;
      r_reg_we     <= reg_we_i;
      if (w_mul_start) begin
        // Previous output was consumed for ready_o to be high; nothing valid until done.
        r_valid <= 1'b0;
      end else begin
        r_valid   <= 1'b1;
        r_wb_data <= w_exec_result;
      end
    end else if (w_mul_done) begin
      r_valid   <= 1'b1;
      r_wb_data <= w_mul_result;
    end else if (wb_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o      = r_valid;
  assign wb_data_o    = r_wb_data;
  assign store_data_o = r_store_data;
  assign load_type_o  = r_load_type;
  assign store_type_o = r_store_type;
  assign rd_addr_o    = r_rd_addr;
  assign reg_we_o     = r_reg_we;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage (WORD_WIDTH = 32).
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge. Build with +define+EX_MUL_EN to cover the
// serial multiplier; the default build covers the single-cycle MUL stub.
module tb_ex_stage;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpSll  = 4'b0010;
  localparam logic [3:0] OpSlt  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpAnd  = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [3:0]  alu_op_i;
  logic [31:0] store_data_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [4:0]  rd_addr_i;
  logic        reg_we_i;
  logic        wb_ready_i;
  logic        valid_o;
  logic [31:0] wb_data_o;
  logic [31:0] store_data_o;
  logic [2:0]  load_type_o;
  logic [1:0]  store_type_o;
  logic [4:0]  rd_addr_o;
  logic        reg_we_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.WORD_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .alu_op_i     (alu_op_i),
    .store_data_i (store_data_i),
    .load_type_i  (load_type_i),
    .store_type_i (store_type_i),
    .rd_addr_i    (rd_addr_i),
    .reg_we_i     (reg_we_i),
    .wb_ready_i   (wb_ready_i),
    .valid_o      (valid_o),
    .wb_data_o    (wb_data_o),
    .store_data_o (store_data_o),
    .load_type_o  (load_type_o),
    .store_type_o (store_type_o),
    .rd_addr_o    (rd_addr_o),
    .reg_we_o     (reg_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus only: apply one set of inputs at the falling edge.
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] lt, input logic [1:0] st,
                       input logic [4:0] rd, input logic we, input logic wbr);
    @(negedge clk);
    valid_i      = v;
    alu_op_i     = op;
    operand_a_i  = a;
    operand_b_i  = b;
    store_data_i = b ^ 32'hA5A5_A5A5;
    load_type_i  = lt;
    store_type_i = st;
    rd_addr_i    = rd;
    reg_we_i     = we;
    wb_ready_i   = wbr;
    #1;
  endtask

  task automatic test_reset();
    // Outputs clear while rst is high from time zero.
    #3;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++;
      $display("FAIL rst0_valid: got %0b want 0", valid_o); end
    n_tests++; if (wb_data_o !== 32'h0) begin n_fail++;
      $display("FAIL rst0_wb_data: got %h want 0", wb_data_o); end
    n_tests++; if (ready_o !== 1'b1) begin n_fail++;
      $display("FAIL rst0_ready: got %0b want 1", ready_o); end
    @(negedge clk); rst = 1'b0;
    // Load nonzero state, then reset mid-cycle to show it is asynchronous.
    drive(1'b1, OpAdd, 32'd1, 32'd2, 3'b101, 2'b00, 5'd9, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_tests++; if (rd_addr_o !== 5'd9) begin n_fail++;
      $display("FAIL pre_rst_rd: got %0d want 9", rd_addr_o); end
    valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_tests++; if ({valid_o, reg_we_o, load_type_o, store_type_o, rd_addr_o} !== 12'h0)
      begin n_fail++; $display("FAIL async_rst_ctrl: got v=%0b we=%0b lt=%0d st=%0d rd=%0d want 0",
        valid_o, reg_we_o, load_type_o, store_type_o, rd_addr_o); end
    n_tests++; if (wb_data_o !== 32'h0 || store_data_o !== 32'h0) begin n_fail++;
      $display("FAIL async_rst_data: got wb=%h sd=%h want 0", wb_data_o, store_data_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [31:0] exp [12];
    ops = '{OpAdd, OpSub, OpSll, OpSlt, OpSlt, OpSltu, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd};
    as  = '{32'hFFFF_FFFF, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF,
            32'hF0F0_F0F0, 32'h8000_0000, 32'h8000_0000, 32'h1234_0000, 32'hF0F0_F0F0};
    bs  = '{32'd1, 32'd7, 32'h24, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
            32'hFF00_FF00, 32'd4, 32'd4, 32'h0000_5678, 32'hFF00_FF00};
    exp = '{32'h0, 32'hFFFF_FFFE, 32'h10, 32'h1, 32'h0, 32'h1, 32'h0,
            32'h0FF0_0FF0, 32'h0800_0000, 32'hF800_0000, 32'h1234_5678, 32'hF000_F000};
    // Back-to-back: wb_ready_i stays high so every cycle accepts with no bubble.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 3'b000, 2'b00, 5'(i + 1), i[0], 1'b1);
      @(posedge clk); #1;
      n_tests++; if (valid_o !== 1'b1) begin n_fail++;
        $display("FAIL alu%0d_valid: got %0b want 1", i, valid_o); end
      n_tests++; if (wb_data_o !== exp[i]) begin n_fail++;
        $display("FAIL alu%0d_data: got %h want %h", i, wb_data_o, exp[i]); end
      n_tests++; if (rd_addr_o !== 5'(i + 1) || reg_we_o !== i[0]) begin n_fail++;
        $display("FAIL alu%0d_rd: got rd=%0d we=%0b want rd=%0d we=%0b",
                 i, rd_addr_o, reg_we_o, i + 1, i[0]); end
    end
    // Consumed with no new instruction: valid drops, data holds.
    drive(1'b0, OpAdd, 32'd0, 32'd0, 3'b000, 2'b00, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++;
      $display("FAIL bubble_valid: got %0b want 0", valid_o); end
    n_tests++; if (wb_data_o !== 32'hF000_F000 || rd_addr_o !== 5'd12) begin n_fail++;
      $display("FAIL bubble_hold: got wb=%h rd=%0d want wb=f000f000 rd=12",
               wb_data_o, rd_addr_o); end
  endtask

  task automatic test_mem_stall();
    drive(1'b1, OpXor, 32'h0000_1000, 32'hFFFF_FFFC, 3'b001, 2'b00, 5'd3, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b1 || wb_data_o !== 32'h0000_0FFC || load_type_o !== 3'b001)
      begin n_fail++; $display("FAIL load_addr: got v=%0b wb=%h lt=%0d want v=1 wb=00000ffc lt=1",
        valid_o, wb_data_o, load_type_o); end
    // WB stalls for three cycles while ID holds a pending ADD.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OpAdd, 32'd2, 32'd3, 3'b000, 2'b00, 5'd4, 1'b1, 1'b0);
      n_tests++; if (ready_o !== 1'b0) begin n_fail++;
        $display("FAIL stall%0d_ready: got %0b want 0", i, ready_o); end
      @(posedge clk); #1;
      n_tests++; if (valid_o !== 1'b1 || wb_data_o !== 32'h0000_0FFC || rd_addr_o !== 5'd3)
        begin n_fail++; $display("FAIL stall%0d_hold: got v=%0b wb=%h rd=%0d want v=1 wb=ffc rd=3",
          i, valid_o, wb_data_o, rd_addr_o); end
    end
    // Consume and accept on the same edge.
    drive(1'b1, OpAdd, 32'd2, 32'd3, 3'b000, 2'b00, 5'd4, 1'b1, 1'b1);
    n_tests++; if (ready_o !== 1'b1) begin n_fail++;
      $display("FAIL release_ready: got %0b want 1", ready_o); end
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b1 || wb_data_o !== 32'd5 || load_type_o !== 3'd0 ||
                   rd_addr_o !== 5'd4)
      begin n_fail++; $display("FAIL no_bubble: got v=%0b wb=%h lt=%0d rd=%0d want v=1 wb=5 lt=0 rd=4",
        valid_o, wb_data_o, load_type_o, rd_addr_o); end
    // Store: address ignores alu_op (SUB would give 0xE0).
    drive(1'b1, OpSub, 32'h100, 32'h20, 3'b000, 2'b10, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_tests++; if (wb_data_o !== 32'h120 || store_type_o !== 2'b10) begin n_fail++;
      $display("FAIL store_addr: got wb=%h st=%0d want wb=00000120 st=2", wb_data_o, store_type_o); end
    n_tests++; if (store_data_o !== 32'hA5A5_A585) begin n_fail++;
      $display("FAIL store_data: got %h want a5a5a585", store_data_o); end
    drive(1'b0, OpAdd, 32'd0, 32'd0, 3'b000, 2'b00, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    drive(1'b1, OpMul, 32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 2'b00, 5'd5, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++;
      $display("FAIL mul_accept: got v=%0b rdy=%0b want v=0 rdy=0", valid_o, ready_o); end
    drive(1'b0, OpAdd, 32'd0, 32'd0, 3'b000, 2'b00, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++;
        $display("FAIL mul_busy%0d: got v=%0b rdy=%0b want v=0 rdy=0", i, valid_o, ready_o); end
    end
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b1 || wb_data_o !== 32'h242D_2080) begin n_fail++;
      $display("FAIL mul_result: got v=%0b wb=%h want v=1 wb=242d2080", valid_o, wb_data_o); end
    n_tests++; if (rd_addr_o !== 5'd5 || ready_o !== 1'b1) begin n_fail++;
      $display("FAIL mul_done_ctl: got rd=%0d rdy=%0b want rd=5 rdy=1", rd_addr_o, ready_o); end
  endtask

  task automatic test_mul_reset();
    drive(1'b1, OpMul, 32'd3, 32'd5, 3'b000, 2'b00, 5'd6, 1'b1, 1'b1);
    @(posedge clk);
    drive(1'b0, OpAdd, 32'd0, 32'd0, 3'b000, 2'b00, 5'd0, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_tests++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++;
      $display("FAIL mul_rst: got v=%0b rdy=%0b want v=0 rdy=1", valid_o, ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++; if (valid_o !== 1'b0 || wb_data_o !== 32'h0) begin n_fail++;
        $display("FAIL mul_abort%0d: got v=%0b wb=%h want v=0 wb=0", i, valid_o, wb_data_o); end
    end
    drive(1'b1, OpAdd, 32'd2, 32'd3, 3'b000, 2'b00, 5'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b1 || wb_data_o !== 32'd5) begin n_fail++;
      $display("FAIL post_rst_add: got v=%0b wb=%h want v=1 wb=5", valid_o, wb_data_o); end
  endtask
`else
  task automatic test_mul_disabled();
    drive(1'b1, OpAdd, 32'd2, 32'd3, 3'b000, 2'b00, 5'd1, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, OpMul, 32'd7, 32'd6, 3'b000, 2'b00, 5'd2, 1'b1, 1'b1);
    n_tests++; if (ready_o !== 1'b1) begin n_fail++;
      $display("FAIL mul_off_ready: got %0b want 1", ready_o); end
    @(posedge clk); #1;
    n_tests++; if (valid_o !== 1'b1 || wb_data_o !== 32'h0 || rd_addr_o !== 5'd2) begin n_fail++;
      $display("FAIL mul_off: got v=%0b wb=%h rd=%0d want v=1 wb=0 rd=2",
               valid_o, wb_data_o, rd_addr_o); end
    n_tests++; if (ready_o !== 1'b1) begin n_fail++;
      $display("FAIL mul_off_after: got rdy=%0b want 1", ready_o); end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    valid_i      = 1'b0;
    operand_a_i  = '0;
    operand_b_i  = '0;
    alu_op_i     = '0;
    store_data_i = '0;
    load_type_i  = '0;
    store_type_i = '0;
    rd_addr_i    = '0;
    reg_we_i     = 1'b0;
    wb_ready_i   = 1'b0;
    test_reset();
    test_alu();
    test_mem_stall();
`ifdef EX_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
